// File: rtl/dram_responder.sv
// Single-bank DRAM device model: open-row FSM with tRCD/tRP timers,
// byte-masked writes, CAS-latency read pipeline and sticky protocol errors.
module dram_responder #(
    parameter int ROW_BITS = 4,
    parameter int COL_BITS = 6,
    parameter int CAS_LAT  = 5,
    parameter int T_RCD    = 4,
    parameter int T_RP     = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        DRAM_CSn,
    input  logic        DRAM_RASn,
    input  logic        DRAM_CASn,
    input  logic [3:0]  DRAM_WEn,
    input  logic [10:0] DRAM_A,
    input  logic [31:0] DRAM_D,
    output logic        DRAM_valid,
    output logic [31:0] DRAM_Q,
    output logic        dram_err,
    output logic [2:0]  dram_err_code
);

    localparam int AW    = ROW_BITS + COL_BITS;
    localparam int DEPTH = 1 << AW;
    localparam int PW    = CAS_LAT * 32;

    typedef enum logic [1:0] {IDLE, ACTIVE, PRECH} state_t;

    state_t                state;
    logic [ROW_BITS-1:0]   row;
    logic [7:0]            rcd_cnt;
    logic [7:0]            rp_cnt;
    logic [31:0]           mem [DEPTH];
    logic [CAS_LAT-1:0]    pv;
    logic [CAS_LAT-1:0]    pv_nxt;
    logic [PW-1:0]         pd;
    logic [PW-1:0]         pd_nxt;
    logic [AW-1:0]         addr;
    logic [31:0]           rd_word;

    logic cs, is_act, is_pre, is_cas, is_rd, is_wr, is_both;
    logic act_ok, pre_go, rd_fire, wr_fire;
    logic err_now;
    logic [2:0] err_code_now;
    logic unused_a;

    assign unused_a = ^DRAM_A;

    assign cs      = !DRAM_CSn;
    assign is_act  = cs && !DRAM_RASn && DRAM_CASn && (DRAM_WEn == 4'hf);
    assign is_pre  = cs && !DRAM_RASn && DRAM_CASn && (DRAM_WEn == 4'h0);
    assign is_cas  = cs && DRAM_RASn && !DRAM_CASn;
    assign is_both = cs && !DRAM_RASn && !DRAM_CASn;
    assign is_rd   = is_cas && (DRAM_WEn == 4'hf);
    assign is_wr   = is_cas && (DRAM_WEn != 4'hf);

    // A PRECHARGING bank whose timer is already zero is as good as idle
    assign act_ok  = is_act && ((state == IDLE) ||
                     ((state == PRECH) && (rp_cnt == 8'd0)));
    assign pre_go  = is_pre && (state == ACTIVE);
    assign rd_fire = is_rd && (state == ACTIVE) && (rcd_cnt == 8'd0);
    assign wr_fire = is_wr && (state == ACTIVE) && (rcd_cnt == 8'd0);

    assign addr    = {row, DRAM_A[COL_BITS-1:0]};
    assign rd_word = mem[addr];

    always_comb begin
        err_now      = 1'b0;
        err_code_now = 3'd0;
        unique case (1'b1)
            is_both: begin
                err_now      = 1'b1;
                err_code_now = 3'd5;
            end
            is_act: begin
                if (state == ACTIVE) begin
                    err_now      = 1'b1;
                    err_code_now = 3'd1;
                end else if (state == PRECH && rp_cnt != 8'd0) begin
                    err_now      = 1'b1;
                    err_code_now = 3'd4;
                end
            end
            is_cas: begin
                if (state != ACTIVE) begin
                    err_now      = 1'b1;
                    err_code_now = 3'd2;
                end else if (rcd_cnt != 8'd0) begin
                    err_now      = 1'b1;
                    err_code_now = 3'd3;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        pv_nxt = (pv << 1) | CAS_LAT'(rd_fire);
        pd_nxt = (pd << 32) | PW'(rd_word);
    end

    assign DRAM_valid = pv[CAS_LAT-1];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_fire && !DRAM_WEn[i])
                mem[addr][8*i +: 8] <= DRAM_D[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            row           <= '0;
            rcd_cnt       <= 8'd0;
            rp_cnt        <= 8'd0;
            pv            <= '0;
            pd            <= '0;
            DRAM_Q        <= 32'd0;
            dram_err      <= 1'b0;
            dram_err_code <= 3'd0;
        end else begin
            pv <= pv_nxt;
            pd <= pd_nxt;
            if (pv_nxt[CAS_LAT-1])
                DRAM_Q <= pd_nxt[PW-1 -: 32];

            if (err_now && !dram_err) begin
                dram_err      <= 1'b1;
                dram_err_code <= err_code_now;
            end

            unique case (state)
                IDLE: begin
                    if (act_ok) begin
                        state   <= ACTIVE;
                        row     <= DRAM_A[ROW_BITS-1:0];
                        rcd_cnt <= 8'(T_RCD - 1);
                    end
                end
                ACTIVE: begin
                    if (rcd_cnt != 8'd0)
                        rcd_cnt <= rcd_cnt - 8'd1;
                    if (pre_go) begin
                        state  <= PRECH;
                        rp_cnt <= 8'(T_RP - 1);
                    end
                end
                PRECH: begin
                    if (act_ok) begin
                        state   <= ACTIVE;
                        row     <= DRAM_A[ROW_BITS-1:0];
                        rcd_cnt <= 8'(T_RCD - 1);
                    end else if (rp_cnt <= 8'd1) begin
                        state  <= IDLE;
                        rp_cnt <= 8'd0;
                    end else begin
                        rp_cnt <= rp_cnt - 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
